score_mem_reader: RTL



---
 rtl/score_pkg.sv | 39 +++
 rtl/score_mem_reader_seg7_decode.sv | 28 ++
 rtl/score_mem_reader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared definitions for the score display path: FSM states, RAM word
// addresses, seven-segment digit patterns and the double-dabble helper.
package score_pkg;

  // Read/convert sequence; one pass visits slot 0 then slot 1, then commits.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    CONVERT = 3'd4,
    STORE   = 3'd5,
    COMMIT  = 3'd6
  } state_e;

  // Word locations written by the score writer.
  localparam int SCORE_ADDR = 0;
  localparam int TOP_ADDR   = 1;

  // Active-low segment patterns, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction: a nibble of 5 or more gets 3 added so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/score_mem_reader_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Codes above 9 cannot occur from a valid conversion and show blank.
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Digit lookup
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_mem_reader.sv
// Polls the current-score and top-score words from game_mem, converts
// each to three BCD digits with a sequential double-dabble, and drives two
// banks of seven-segment digits. Both scores are published together in a
// single COMMIT cycle so the display never shows a half-updated pair.
//
// Read handshake with the RAM: the address is held on rd_address from ADDR
// through CAPTURE; the RAM registers it at the end of ADDR and rd_q is
// sampled only in CAPTURE, two cycles after the address change.
module score_mem_reader
  import score_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int POLL_CYCLES = 500000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [DATA_W-1:0] rd_q,
  output logic [DATA_W-1:0] cur_score,
  output logic [DATA_W-1:0] top_score,
  output logic [11:0]       cur_bcd,
  output logic [11:0]       top_bcd,
  output logic [20:0]       seg_cur,
  output logic [20:0]       seg_top,
  output logic              update,
  output state_e            dbg_state_o
);

  localparam int CNT_W  = $clog2(POLL_CYCLES);
  localparam int ITER_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SH_W   = 12 + DATA_W;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(POLL_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                slot_q, slot_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [SH_W-1:0]     sh_adj;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [DATA_W-1:0]   stg0_score_q, stg0_score_d;
  logic [DATA_W-1:0]   stg1_score_q, stg1_score_d;
  logic [11:0]         stg0_bcd_q, stg0_bcd_d;
  logic [11:0]         stg1_bcd_q, stg1_bcd_d;
  logic [DATA_W-1:0]   cur_score_q, cur_score_d;
  logic [DATA_W-1:0]   top_score_q, top_score_d;
  logic [11:0]         cur_bcd_q, cur_bcd_d;
  logic [11:0]         top_bcd_q, top_bcd_d;
  logic                update_q, update_d;

  // State and datapath registers; reset aborts any pass in flight.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      slot_q       <= 1'b0;
      iter_q       <= '0;
      sh_q         <= '0;
      bin_q        <= '0;
      stg0_score_q <= '0;
      stg1_score_q <= '0;
      stg0_bcd_q   <= '0;
      stg1_bcd_q   <= '0;
      cur_score_q  <= '0;
      top_score_q  <= '0;
      cur_bcd_q    <= '0;
      top_bcd_q    <= '0;
      update_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      iter_q       <= iter_d;
      sh_q         <= sh_d;
      bin_q        <= bin_d;
      stg0_score_q <= stg0_score_d;
      stg1_score_q <= stg1_score_d;
      stg0_bcd_q   <= stg0_bcd_d;
      stg1_bcd_q   <= stg1_bcd_d;
      cur_score_q  <= cur_score_d;
      top_score_q  <= top_score_d;
      cur_bcd_q    <= cur_bcd_d;
      top_bcd_q    <= top_bcd_d;
      update_q     <= update_d;
    end
  end

  // Add-3 correction on the three BCD nibbles ahead of each shift.
  always_comb begin
    sh_adj                        = sh_q;
    sh_adj[DATA_W+3  : DATA_W]    = dd_adjust(sh_q[DATA_W+3  : DATA_W]);
    sh_adj[DATA_W+7  : DATA_W+4]  = dd_adjust(sh_q[DATA_W+7  : DATA_W+4]);
    sh_adj[DATA_W+11 : DATA_W+8]  = dd_adjust(sh_q[DATA_W+11 : DATA_W+8]);
  end

  // Next-state logic: poll counter in IDLE, per-slot read/convert/store,
  // then a single commit of both staged results.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    iter_d       = iter_q;
    sh_d         = sh_q;
    bin_d        = bin_q;
    stg0_score_d = stg0_score_q;
    stg1_score_d = stg1_score_q;
    stg0_bcd_d   = stg0_bcd_q;
    stg1_bcd_d   = stg1_bcd_q;
    cur_score_d  = cur_score_q;
    top_score_d  = top_score_q;
    cur_bcd_d    = cur_bcd_q;
    top_bcd_d    = top_bcd_q;
    update_d     = 1'b0;

    case (state_q)
      IDLE: begin
        slot_d = 1'b0;
        if (enable) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ADDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ADDR:    state_d = WAIT;
      WAIT:    state_d = CAPTURE;
      CAPTURE: begin
        sh_d    = {12'b0, rd_q};
        bin_d   = rd_q;
        iter_d  = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        sh_d   = sh_adj << 1;
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_LAST) begin
          state_d = STORE;
        end
      end
      STORE: begin
        if (!slot_q) begin
          stg0_score_d = bin_q;
          stg0_bcd_d   = sh_q[SH_W-1:DATA_W];
          slot_d       = 1'b1;
          state_d      = ADDR;
        end else begin
          stg1_score_d = bin_q;
          stg1_bcd_d   = sh_q[SH_W-1:DATA_W];
          state_d      = COMMIT;
        end
      end
      COMMIT: begin
        cur_score_d = stg0_score_q;
        cur_bcd_d   = stg0_bcd_q;
        top_score_d = stg1_score_q;
        top_bcd_d   = stg1_bcd_q;
        update_d    = 1'b1;
        slot_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The read address is a pure function of registered state, so it only
  // carries the slot while a read is outstanding and is 0 otherwise.
  always_comb begin
    rd_address = '0;
    if (state_q == ADDR || state_q == WAIT || state_q == CAPTURE) begin
      rd_address = slot_q ? ADDR_W'(TOP_ADDR) : ADDR_W'(SCORE_ADDR);
    end
  end

  assign cur_score   = cur_score_q;
  assign top_score   = top_score_q;
  assign cur_bcd     = cur_bcd_q;
  assign top_bcd     = top_bcd_q;
  assign update      = update_q;
  assign dbg_state_o = state_q;

  // Six digit decoders, fed only by the committed BCD registers.
  for (genvar d = 0; d < 3; d++) begin : g_digit
    seg7_decode u_cur (
      .bcd_i (cur_bcd_q[4*d +: 4]),
      .seg_o (seg_cur[7*d +: 7])
    );
    seg7_decode u_top (
      .bcd_i (top_bcd_q[4*d +: 4]),
      .seg_o (seg_top[7*d +: 7])
    );
  end

endmodule
